// File: rtl/alu_issue_stage_if.sv
// Decode-to-issue handshake bundle for alu_issue_stage: instruction fields plus valid/ready.
// master = decode side, slave = issue stage.
interface alu_issue_stage_if #(
  parameter int DATAPATH_WIDTH = 64,
  parameter int IMM_WIDTH      = 16
);
  logic                      id_valid;
  logic                      id_ready;
  logic [3:0]                id_alu_ctrl;
  logic [4:0]                id_shift;
  logic [4:0]                id_rs1;
  logic [4:0]                id_rs2;
  logic [4:0]                id_rd;
  logic                      id_rd_we;
  logic                      id_is_load;
  logic                      id_use_imm;
  logic [IMM_WIDTH-1:0]      id_imm;
  logic [DATAPATH_WIDTH-1:0] id_rs1_data;
  logic [DATAPATH_WIDTH-1:0] id_rs2_data;

  modport master (
    output id_valid, id_alu_ctrl, id_shift, id_rs1, id_rs2, id_rd,
           id_rd_we, id_is_load, id_use_imm, id_imm, id_rs1_data, id_rs2_data,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_alu_ctrl, id_shift, id_rs1, id_rs2, id_rd,
           id_rd_we, id_is_load, id_use_imm, id_imm, id_rs1_data, id_rs2_data,
    output id_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-issue register feeding the 64-bit ALU: operand selection, hazard bubbles, stall counter.
// Macro ALU_FWD_EN: defined = EX/MEM forwarding with load-use stalls; undefined = stall on any in-flight writer.
module alu_issue_stage #(
  parameter int DATAPATH_WIDTH  = 64,
  parameter int IMM_WIDTH       = 16,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  alu_issue_stage_if.slave           dec,
  input  logic [DATAPATH_WIDTH-1:0]  ex_result,
  input  logic                       mem_we,
  input  logic [4:0]                 mem_rd,
  input  logic [DATAPATH_WIDTH-1:0]  mem_data,
  input  logic                       ex_ready,
  output logic                       ex_valid,
  output logic [DATAPATH_WIDTH-1:0]  a_out,
  output logic [DATAPATH_WIDTH-1:0]  b_out,
  output logic [3:0]                 alu_ctrl_out,
  output logic [4:0]                 shift_out,
  output logic [4:0]                 ex_rd,
  output logic                       ex_rd_we,
  output logic                       ex_is_load,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [4:0]                 REG_ZERO  = 5'd0;
  localparam logic [DATAPATH_WIDTH-1:0]  DATA_ZERO = {DATAPATH_WIDTH{1'b0}};
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ZERO  = {STALL_CNT_WIDTH{1'b0}};
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX   = {STALL_CNT_WIDTH{1'b1}};
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE   = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [DATAPATH_WIDTH-1:0] sign_ext_imm(input logic [IMM_WIDTH-1:0] imm);
    return {{(DATAPATH_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  endfunction

  // r0 is hard-wired zero, so it never participates in a match
  function automatic logic src_match(input logic [4:0] rs, input logic [4:0] rd);
    return (rs != REG_ZERO) && (rs == rd);
  endfunction

  function automatic logic [DATAPATH_WIDTH-1:0] pick_operand(
    input logic [4:0]                rs,
    input logic [DATAPATH_WIDTH-1:0] rf_data,
    input logic                      ex_hit,
    input logic                      mem_hit,
    input logic [DATAPATH_WIDTH-1:0] ex_val,
    input logic [DATAPATH_WIDTH-1:0] mem_val
  );
    logic [DATAPATH_WIDTH-1:0] val;
    if (ex_hit) begin
      val = ex_val;
    end else if (mem_hit) begin
      val = mem_val;
    end else if (rs != REG_ZERO) begin
      val = rf_data;
    end else begin
      val = DATA_ZERO;
    end
    return val;
  endfunction

  logic                       ex_valid_r;
  logic [DATAPATH_WIDTH-1:0]  a_r;
  logic [DATAPATH_WIDTH-1:0]  b_r;
  logic [3:0]                 alu_ctrl_r;
  logic [4:0]                 shift_r;
  logic [4:0]                 ex_rd_r;
  logic                       ex_rd_we_r;
  logic                       ex_is_load_r;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_r;

  logic                       rs2_used_s;
  logic                       hazard_s;
  logic                       ex_hit1_s;
  logic                       ex_hit2_s;
  logic                       mem_hit1_s;
  logic                       mem_hit2_s;
  logic                       transfer_s;
  logic                       bubble_s;
  logic [DATAPATH_WIDTH-1:0]  op_a_s;
  logic [DATAPATH_WIDTH-1:0]  op_b_s;
  logic [DATAPATH_WIDTH-1:0]  rs2_val_s;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_next_s;

  always_comb begin
    rs2_used_s = ~dec.id_use_imm;
  end

`ifdef ALU_FWD_EN
  logic ex_fwd_src_s;
  logic ex_load_src_s;

  // A non-load in EX forwards its ALU result; a load in EX has no data yet and forces a bubble
  always_comb begin
    ex_fwd_src_s  = ex_valid_r & ex_rd_we_r & ~ex_is_load_r;
    ex_load_src_s = ex_valid_r & ex_rd_we_r & ex_is_load_r;
    ex_hit1_s     = ex_fwd_src_s & src_match(dec.id_rs1, ex_rd_r);
    ex_hit2_s     = ex_fwd_src_s & src_match(dec.id_rs2, ex_rd_r);
    mem_hit1_s    = mem_we & src_match(dec.id_rs1, mem_rd);
    mem_hit2_s    = mem_we & src_match(dec.id_rs2, mem_rd);
    hazard_s      = ex_load_src_s &
                    (src_match(dec.id_rs1, ex_rd_r) |
                     (rs2_used_s & src_match(dec.id_rs2, ex_rd_r)));
  end
`else
  logic ex_wr_s;
  logic src1_busy_s;
  logic src2_busy_s;
  logic unused_fwd_s;

  // Without forwarding, any writer still in EX or MEM blocks its readers until write-back
  always_comb begin
    ex_hit1_s    = 1'b0;
    ex_hit2_s    = 1'b0;
    mem_hit1_s   = 1'b0;
    mem_hit2_s   = 1'b0;
    ex_wr_s      = ex_valid_r & ex_rd_we_r;
    src1_busy_s  = (ex_wr_s & src_match(dec.id_rs1, ex_rd_r)) |
                   (mem_we & src_match(dec.id_rs1, mem_rd));
    src2_busy_s  = (ex_wr_s & src_match(dec.id_rs2, ex_rd_r)) |
                   (mem_we & src_match(dec.id_rs2, mem_rd));
    hazard_s     = src1_busy_s | (rs2_used_s & src2_busy_s);
  end

  assign unused_fwd_s = ^{ex_result, mem_data};
`endif

  always_comb begin
    op_a_s    = pick_operand(dec.id_rs1, dec.id_rs1_data, ex_hit1_s, mem_hit1_s, ex_result, mem_data);
    rs2_val_s = pick_operand(dec.id_rs2, dec.id_rs2_data, ex_hit2_s, mem_hit2_s, ex_result, mem_data);
    if (dec.id_use_imm) begin
      op_b_s = sign_ext_imm(dec.id_imm);
    end else begin
      op_b_s = rs2_val_s;
    end
  end

  always_comb begin
    transfer_s = dec.id_valid & ex_ready & ~hazard_s;
    bubble_s   = dec.id_valid & ex_ready & hazard_s;
    if (bubble_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_next_s = stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_next_s = stall_cnt_r;
    end
  end

  assign dec.id_ready = ex_ready & ~hazard_s;

  // Issue register: a frozen back end (ex_ready=0) leaves every field untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_r   <= 1'b0;
      a_r          <= DATA_ZERO;
      b_r          <= DATA_ZERO;
      alu_ctrl_r   <= 4'd0;
      shift_r      <= 5'd0;
      ex_rd_r      <= REG_ZERO;
      ex_rd_we_r   <= 1'b0;
      ex_is_load_r <= 1'b0;
    end else if (transfer_s) begin
      ex_valid_r   <= 1'b1;
      a_r          <= op_a_s;
      b_r          <= op_b_s;
      alu_ctrl_r   <= dec.id_alu_ctrl;
      shift_r      <= dec.id_shift;
      ex_rd_r      <= dec.id_rd;
      ex_rd_we_r   <= dec.id_rd_we;
      ex_is_load_r <= dec.id_is_load;
    end else if (bubble_s) begin
      ex_valid_r   <= 1'b0;
      ex_rd_we_r   <= 1'b0;
      ex_is_load_r <= 1'b0;
    end else if (ex_ready) begin
      ex_valid_r   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= CNT_ZERO;
    end else begin
      stall_cnt_r <= stall_cnt_next_s;
    end
  end

  assign ex_valid     = ex_valid_r;
  assign a_out        = a_r;
  assign b_out        = b_r;
  assign alu_ctrl_out = alu_ctrl_r;
  assign shift_out    = shift_r;
  assign ex_rd        = ex_rd_r;
  assign ex_rd_we     = ex_rd_we_r;
  assign ex_is_load   = ex_is_load_r;
  assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: the reference holds program-order register values, committed
// register-file state and EX/MEM occupancy; operands are judged by the value they must carry.
module tb_alu_issue_stage;
  localparam int DW  = 64;
  localparam int IW  = 16;
  localparam int SCW = 6;
  localparam longint unsigned CNT_SAT = (64'd1 << SCW) - 64'd1;
`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [3:0]  ctrl;
    logic [4:0]  shift;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_load;
    logic        use_imm;
    logic [15:0] imm;
    logic [63:0] token;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } instr_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  ex_result;
  logic           mem_we;
  logic [4:0]     mem_rd;
  logic [DW-1:0]  mem_data;
  logic           ex_ready;
  logic           ex_valid;
  logic [DW-1:0]  a_out;
  logic [DW-1:0]  b_out;
  logic [3:0]     alu_ctrl_out;
  logic [4:0]     shift_out;
  logic [4:0]     ex_rd;
  logic           ex_rd_we;
  logic           ex_is_load;
  logic [SCW-1:0] stall_cnt;

  alu_issue_stage_if #(.DATAPATH_WIDTH(DW), .IMM_WIDTH(IW)) dec_bus ();

  alu_issue_stage #(.DATAPATH_WIDTH(DW), .IMM_WIDTH(IW), .STALL_CNT_WIDTH(SCW)) dut (
    .clk(clk), .reset(reset), .dec(dec_bus.slave),
    .ex_result(ex_result), .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .a_out(a_out), .b_out(b_out),
    .alu_ctrl_out(alu_ctrl_out), .shift_out(shift_out), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              failures = 0;
  instr_t          pend;
  instr_t          ex_i;
  instr_t          mem_i;
  bit              pend_v = 1'b0;
  bit              ex_v = 1'b0;
  bit              mem_v = 1'b0;
  longint unsigned cnt = 0;
  logic [63:0]     committed [32];
  logic [63:0]     arch [32];
  instr_t          dir_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] imm_value(input logic [15:0] imm);
    longint v;
    v = longint'(imm);
    if (imm[15]) v = v - 65536;
    return 64'(v);
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(99) < 80) return 5'($urandom_range(3));
    return 5'($urandom_range(31));
  endfunction

  function automatic instr_t mk(input logic [3:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input bit we, input bit ld, input bit ui,
                                input logic [15:0] imm, input logic [63:0] tok);
    instr_t t;
    t.ctrl = ctrl; t.shift = 5'($urandom); t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.rd_we = we; t.is_load = ld; t.use_imm = ui; t.imm = imm; t.token = tok;
    t.exp_a = 64'd0; t.exp_b = 64'd0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    return mk(4'($urandom_range(9, 1)), pick_reg(), pick_reg(), pick_reg(),
              $urandom_range(99) < 85, $urandom_range(99) < 35, $urandom_range(99) < 30,
              16'($urandom), {$urandom, $urandom});
  endfunction

  // Program order: operands see every earlier writer; the new result becomes the architectural value
  task automatic admit(input instr_t t);
    pend = t;
    pend.exp_a = (t.rs1 == 5'd0) ? 64'd0 : arch[t.rs1];
    pend.exp_b = t.use_imm ? imm_value(t.imm) : ((t.rs2 == 5'd0) ? 64'd0 : arch[t.rs2]);
    if (t.rd_we && t.rd != 5'd0) arch[t.rd] = t.token;
    pend_v = 1'b1;
  endtask

  function automatic bit reads(input instr_t c, input logic [4:0] rd);
    return (rd != 5'd0) && ((c.rs1 == rd) || (!c.use_imm && c.rs2 == rd));
  endfunction

  function automatic bit model_hazard(input instr_t c);
    bit hit_ex;
    bit hit_mem;
    hit_ex  = ex_v && ex_i.rd_we && reads(c, ex_i.rd);
    hit_mem = mem_v && mem_i.rd_we && reads(c, mem_i.rd);
    if (FWD) return hit_ex && ex_i.is_load;
    return hit_ex || hit_mem;
  endfunction

  task automatic model_reset();
    ex_i = '{default: '0};
    ex_v = 1'b0; mem_v = 1'b0; pend_v = 1'b0; cnt = 0;
    for (int r = 0; r < 32; r++) arch[r] = committed[r];
  endtask

  task automatic run_cycle(input int ready_pct, input bit do_reset);
    instr_t cur;
    bit     rdy;
    bit     hz;
    @(negedge clk);
    if (!pend_v && !do_reset) begin
      if (dir_q.size() != 0) admit(dir_q.pop_front());
      else if ($urandom_range(99) < 70) admit(rand_instr());
    end
    cur = pend_v ? pend : rand_instr();
    rdy = ($urandom_range(99) < ready_pct);
    reset = do_reset;
    dec_bus.id_valid    = pend_v;
    dec_bus.id_alu_ctrl = cur.ctrl;
    dec_bus.id_shift    = cur.shift;
    dec_bus.id_rs1      = cur.rs1;
    dec_bus.id_rs2      = cur.rs2;
    dec_bus.id_rd       = cur.rd;
    dec_bus.id_rd_we    = cur.rd_we;
    dec_bus.id_is_load  = cur.is_load;
    dec_bus.id_use_imm  = cur.use_imm;
    dec_bus.id_imm      = cur.imm;
    dec_bus.id_rs1_data = (cur.rs1 == 5'd0) ? {$urandom, $urandom} : committed[cur.rs1];
    dec_bus.id_rs2_data = (cur.rs2 == 5'd0) ? {$urandom, $urandom} : committed[cur.rs2];
    ex_result = (ex_v && !ex_i.is_load) ? ex_i.token : {$urandom, $urandom};
    mem_we    = mem_v && mem_i.rd_we;
    mem_rd    = mem_v ? mem_i.rd : 5'($urandom);
    mem_data  = mem_v ? mem_i.token : {$urandom, $urandom};
    ex_ready  = rdy;
    #1;
    hz = model_hazard(cur);
    check_eq("id_ready", 64'(dec_bus.id_ready), 64'(rdy && !hz));
    if (do_reset) begin
      model_reset();
    end else if (rdy) begin
      if (mem_v && mem_i.rd_we && mem_i.rd != 5'd0) committed[mem_i.rd] = mem_i.token;
      mem_i = ex_i;
      mem_v = ex_v;
      if (pend_v && !hz) begin
        ex_i = pend; ex_v = 1'b1; pend_v = 1'b0;
      end else if (pend_v) begin
        ex_v = 1'b0; ex_i.rd_we = 1'b0; ex_i.is_load = 1'b0;
        if (cnt < CNT_SAT) cnt++;
      end else begin
        ex_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("ex_valid", 64'(ex_valid), 64'(ex_v));
    check_eq("a_out", a_out, ex_i.exp_a);
    check_eq("b_out", b_out, ex_i.exp_b);
    check_eq("alu_ctrl_out", 64'(alu_ctrl_out), 64'(ex_i.ctrl));
    check_eq("shift_out", 64'(shift_out), 64'(ex_i.shift));
    check_eq("ex_rd", 64'(ex_rd), 64'(ex_i.rd));
    check_eq("ex_rd_we", 64'(ex_rd_we), 64'(ex_i.rd_we));
    check_eq("ex_is_load", 64'(ex_is_load), 64'(ex_i.is_load));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(cnt));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (dir_q.size() != 0 || pend_v); i++) run_cycle(100, 1'b0);
  endtask

  initial begin
    reset = 1'b1; ex_ready = 1'b0; mem_we = 1'b0; mem_rd = 5'd0;
    ex_result = 64'd0; mem_data = 64'd0;
    dec_bus.id_valid = 1'b1; dec_bus.id_alu_ctrl = 4'd0; dec_bus.id_shift = 5'd0;
    dec_bus.id_rs1 = 5'd0; dec_bus.id_rs2 = 5'd0; dec_bus.id_rd = 5'd0;
    dec_bus.id_rd_we = 1'b0; dec_bus.id_is_load = 1'b0; dec_bus.id_use_imm = 1'b0;
    dec_bus.id_imm = 16'd0; dec_bus.id_rs1_data = 64'd0; dec_bus.id_rs2_data = 64'd0;
    committed[0] = 64'd0;
    for (int r = 1; r < 32; r++) committed[r] = {$urandom, $urandom};
    committed[1] = 64'd5;
    committed[2] = 64'd7;
    model_reset();
    pend = rand_instr();
    pend_v = 1'b1;
    run_cycle(100, 1'b1);
    run_cycle(100, 1'b1);

    // ADD/SUB chain, load-use with negative immediate, r0 source behind an rd=0 writer
    dir_q.push_back(mk(4'd1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 16'd0, 64'd12));
    dir_q.push_back(mk(4'd2, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, 16'd0, 64'h44));
    dir_q.push_back(mk(4'd1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 16'd8, 64'h10));
    dir_q.push_back(mk(4'd1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 16'hFFFF, 64'h66));
    dir_q.push_back(mk(4'd3, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 16'd0, 64'hDEAD));
    dir_q.push_back(mk(4'd1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 16'd0, 64'h77));
    drain(60);

    // Back end frozen with an instruction waiting
    dir_q.push_back(mk(4'd4, 5'd6, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 16'd0, 64'h88));
    for (int i = 0; i < 3; i++) run_cycle(0, 1'b0);
    drain(20);

    // Repeated load-use pairs drive the counter into saturation
    for (int i = 0; i < 80; i++) begin
      dir_q.push_back(mk(4'd1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 16'd4, {$urandom, $urandom}));
      dir_q.push_back(mk(4'd1, 5'd9, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 16'd0, {$urandom, $urandom}));
    end
    drain(800);
    check_eq("stall_cnt_saturated", 64'(stall_cnt), CNT_SAT);

    for (int i = 0; i < 1500; i++) run_cycle(80, ($urandom_range(999) < 3));
    run_cycle(100, 1'b1);
    for (int i = 0; i < 1500; i++) run_cycle(80, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
